// File: rtl/param_up_sampler_pkg.sv
// Shared constants, FSM state type and phase-width helper for the up-sampler.
package up_sampler_pkg;

   localparam int MODE_ZERO = 0;
   localparam int MODE_HOLD = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Phase counter width; at least one bit even when FACTOR is 2.
   function automatic int phase_w(input int factor);
      return (factor <= 2) ? 1 : $clog2(factor);
   endfunction

endpackage

// File: rtl/param_up_sampler_if.sv
// Sample-side bus of the up-sampler: input strobe/sample, output-rate samples and flags.
interface param_up_sampler_if #(
   parameter int WIDTH  = 18,
   parameter int FACTOR = 4
);
   import up_sampler_pkg::*;

   localparam int PW = phase_w(FACTOR);

   // sam_en is a one-cycle strobe with no back-pressure: x_in is taken on every
   // cycle sam_en is high. y_valid qualifies y on every cycle it is high.
   logic                    sam_en;
   logic signed [WIDTH-1:0] x_in;
   logic                    clr_flags;
   logic signed [WIDTH-1:0] y;
   logic                    y_valid;
   logic [PW-1:0]           phase;
   logic                    underrun;
   logic                    overrun;

   modport master (
      output sam_en, x_in, clr_flags,
      input  y, y_valid, phase, underrun, overrun
   );

   modport slave (
      input  sam_en, x_in, clr_flags,
      output y, y_valid, phase, underrun, overrun
   );

endinterface

// File: rtl/param_up_sampler_phase_ctr.sv
// Modulo-FACTOR phase counter with synchronous restart and a wrap pulse.
module up_sampler_phase_ctr
   import up_sampler_pkg::*;
#(
   parameter int FACTOR = 4,
   parameter int PW     = phase_w(FACTOR)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          restart,
   output logic [PW-1:0] phase,
   output logic          wrap
);

   localparam logic [PW-1:0] LAST = PW'(FACTOR - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= '0;
      end else if (restart) begin
         phase <= '0;
      end else if (en) begin
         phase <= (phase == LAST) ? '0 : phase + PW'(1);
      end
   end

   // A restart overrides the natural wrap, so it never reports as one.
   assign wrap = en && !restart && (phase == LAST);

endmodule

// File: rtl/param_up_sampler.sv
// Integer up-sampler: zero-stuffing or zero-order hold by FACTOR, with sticky
// underrun/overrun flags for strobes that drift off the frame boundary.
module param_up_sampler
   import up_sampler_pkg::*;
#(
   parameter int WIDTH  = 18,
   parameter int FACTOR = 4,
   parameter int MODE   = MODE_ZERO
) (
   input  logic                clk,
   input  logic                reset,
   param_up_sampler_if.slave   bus,
   output state_t              state_dbg
);

   localparam int PW = phase_w(FACTOR);
   localparam logic [PW-1:0] LAST = PW'(FACTOR - 1);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "param_up_sampler: WIDTH must be 2..32");
   end
   if (FACTOR < 2 || FACTOR > 16) begin : g_bad_factor
      $fatal(1, "param_up_sampler: FACTOR must be 2..16");
   end
   if (MODE != MODE_ZERO && MODE != MODE_HOLD) begin : g_bad_mode
      $fatal(1, "param_up_sampler: MODE must be MODE_ZERO or MODE_HOLD");
   end

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] y_q, y_d;
   logic signed [WIDTH-1:0] held_q, held_d;
   logic                    y_valid_q, y_valid_d;
   logic                    underrun_q, overrun_q;
   logic [PW-1:0]           phase;
   logic                    wrap;
   logic                    run;
   logic                    und_set, ovr_set;

   assign run = (state_q == ST_RUN);

   up_sampler_phase_ctr #(
      .FACTOR (FACTOR),
      .PW     (PW)
   ) u_phase_ctr (
      .clk     (clk),
      .reset   (reset),
      .en      (run),
      .restart (bus.sam_en),
      .phase   (phase),
      .wrap    (wrap)
   );

   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      y_valid_d = 1'b0;
      y_d       = (MODE == MODE_HOLD) ? held_q : '0;
      case (state_q)
         ST_IDLE: begin
            y_d = '0;
            if (bus.sam_en) begin
               state_d   = ST_RUN;
               held_d    = bus.x_in;
               y_d       = bus.x_in;
               y_valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            y_valid_d = 1'b1;
            if (bus.sam_en) begin
               held_d = bus.x_in;
               y_d    = bus.x_in;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A strobe at the last phase is on time; any earlier one is a resync.
   assign und_set = run && wrap;
   assign ovr_set = run && bus.sam_en && (phase != LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         held_q     <= '0;
         y_q        <= '0;
         y_valid_q  <= 1'b0;
         underrun_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         if (und_set)            underrun_q <= 1'b1;
         else if (bus.clr_flags) underrun_q <= 1'b0;
         if (ovr_set)            overrun_q  <= 1'b1;
         else if (bus.clr_flags) overrun_q  <= 1'b0;
      end
   end

   assign bus.y        = y_q;
   assign bus.y_valid  = y_valid_q;
   assign bus.phase    = phase;
   assign bus.underrun = underrun_q;
   assign bus.overrun  = overrun_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_param_up_sampler.sv
// Directed bench for param_up_sampler across zero-stuff and hold configurations.
module tb_param_up_sampler;
   import up_sampler_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   param_up_sampler_if #(.WIDTH(18), .FACTOR(4)) bus_a ();
   param_up_sampler_if #(.WIDTH(18), .FACTOR(3)) bus_b ();
   param_up_sampler_if #(.WIDTH(18), .FACTOR(4)) bus_c ();
   state_t st_a, st_b, st_c;

   param_up_sampler #(.WIDTH(18), .FACTOR(4), .MODE(MODE_ZERO)) u_a (
      .clk(clk), .reset(reset), .bus(bus_a), .state_dbg(st_a));
   param_up_sampler #(.WIDTH(18), .FACTOR(3), .MODE(MODE_HOLD)) u_b (
      .clk(clk), .reset(reset), .bus(bus_b), .state_dbg(st_b));
   param_up_sampler #(.WIDTH(18), .FACTOR(4), .MODE(MODE_HOLD)) u_c (
      .clk(clk), .reset(reset), .bus(bus_c), .state_dbg(st_c));

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic en, input int x, input logic clr);
      bus_a.sam_en = en; bus_a.x_in = x[17:0]; bus_a.clr_flags = clr;
      tick();
   endtask

   task automatic drive_b(input logic en, input int x);
      bus_b.sam_en = en; bus_b.x_in = x[17:0]; bus_b.clr_flags = 1'b0;
      tick();
   endtask

   task automatic drive_c(input logic en, input int x);
      bus_c.sam_en = en; bus_c.x_in = x[17:0]; bus_c.clr_flags = 1'b0;
      tick();
   endtask

   task automatic check_a(input string tag, input int y, input int ph, input int v);
      check({tag, "_y"}, int'(bus_a.y), y);
      check({tag, "_phase"}, int'(bus_a.phase), ph);
      check({tag, "_valid"}, int'(bus_a.y_valid), v);
   endtask

   initial begin
      int samples[5];
      samples = '{100, -200, 300, -131072, 131071};

      reset = 1'b1;
      bus_a.sam_en = 0; bus_a.x_in = '0; bus_a.clr_flags = 0;
      bus_b.sam_en = 0; bus_b.x_in = '0; bus_b.clr_flags = 0;
      bus_c.sam_en = 0; bus_c.x_in = '0; bus_c.clr_flags = 0;
      repeat (2) tick();
      check_a("rst", 0, 0, 0);
      check("rst_under", int'(bus_a.underrun), 0);
      check("rst_over", int'(bus_a.overrun), 0);
      check("rst_state", int'(st_a), int'(ST_IDLE));
      reset = 1'b0;
      tick();
      check("idle_valid", int'(bus_b.y_valid), 0);

      // Three-phase hold: -5 then 7 at nominal timing, then one missed strobe.
      drive_b(1, -5);
      check("b0_y", int'(bus_b.y), -5);   check("b0_ph", int'(bus_b.phase), 0);
      check("b0_valid", int'(bus_b.y_valid), 1);
      drive_b(0, 0);
      check("b1_y", int'(bus_b.y), -5);   check("b1_ph", int'(bus_b.phase), 1);
      drive_b(0, 0);
      check("b2_y", int'(bus_b.y), -5);   check("b2_ph", int'(bus_b.phase), 2);
      drive_b(1, 7);
      check("b3_y", int'(bus_b.y), 7);    check("b3_ph", int'(bus_b.phase), 0);
      drive_b(0, 0);
      check("b4_y", int'(bus_b.y), 7);    check("b4_valid", int'(bus_b.y_valid), 1);
      drive_b(0, 0);
      check("b5_y", int'(bus_b.y), 7);    check("b5_ph", int'(bus_b.phase), 2);
      check("b5_under", int'(bus_b.underrun), 0);
      check("b5_over", int'(bus_b.overrun), 0);
      drive_b(0, 0);
      check("b_ur_y", int'(bus_b.y), 7);  check("b_ur_ph", int'(bus_b.phase), 0);
      check("b_ur_flag", int'(bus_b.underrun), 1);

      // Hold mode with full-scale extremes.
      drive_c(1, -131072);
      check("c_min_y", int'(bus_c.y), -131072);
      for (int k = 1; k < 4; k++) begin
         drive_c(0, 0);
         check($sformatf("c_min_hold%0d", k), int'(bus_c.y), -131072);
      end
      drive_c(1, 131071);
      check("c_max_y", int'(bus_c.y), 131071);
      drive_c(0, 0);
      check("c_max_hold", int'(bus_c.y), 131071);
      check("c_flags", int'(bus_c.underrun) + int'(bus_c.overrun), 0);

      // Zero-stuff by 4 at nominal timing, including extremes.
      foreach (samples[i]) begin
         exp_q.push_back(samples[i]);
         for (int k = 1; k < 4; k++) exp_q.push_back(0);
      end
      foreach (samples[i]) begin
         for (int k = 0; k < 4; k++) begin
            drive_a(k == 0, samples[i], 0);
            check_a($sformatf("a_s%0d_p%0d", i, k), int'(exp_q.pop_front()), k, 1);
         end
      end
      check("a_nom_under", int'(bus_a.underrun), 0);
      check("a_nom_over", int'(bus_a.overrun), 0);

      // Underrun after sample 50.
      drive_a(1, 50, 0);
      check_a("a_u0", 50, 0, 1);
      repeat (3) drive_a(0, 0, 0);
      check("a_u3_under", int'(bus_a.underrun), 0);
      drive_a(0, 0, 0);
      check_a("a_uwrap", 0, 0, 1);
      check("a_uwrap_flag", int'(bus_a.underrun), 1);
      drive_a(0, 0, 0);
      check("a_usticky", int'(bus_a.underrun), 1);
      drive_a(0, 0, 1);
      check("a_uclr", int'(bus_a.underrun), 0);
      check("a_uclr_ph", int'(bus_a.phase), 2);

      // Overrun: early strobe at phase 1, then set/clear collision.
      drive_a(0, 0, 0);
      drive_a(1, 20, 0);
      check_a("a_o_sync", 20, 0, 1);
      drive_a(0, 0, 0);
      drive_a(1, 9, 0);
      check_a("a_o_early", 9, 0, 1);
      check("a_o_flag", int'(bus_a.overrun), 1);
      drive_a(1, 11, 1);
      check_a("a_o_collide", 11, 0, 1);
      check("a_o_setwins", int'(bus_a.overrun), 1);
      drive_a(0, 0, 1);
      check("a_o_clr", int'(bus_a.overrun), 0);
      drive_a(1, 3, 0);
      drive_a(1, 4, 0);
      check_a("a_o_held", 4, 0, 1);
      check("a_o_held_flag", int'(bus_a.overrun), 1);

      // Reset mid-frame at phase 2, then restart from IDLE.
      drive_a(0, 0, 0);
      drive_a(0, 0, 0);
      check("a_r_pre_ph", int'(bus_a.phase), 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_a("a_r", 0, 0, 0);
      check("a_r_flags", int'(bus_a.underrun) + int'(bus_a.overrun), 0);
      check("a_r_state", int'(st_a), int'(ST_IDLE));
      drive_a(0, 0, 0);
      check_a("a_r_idle", 0, 0, 0);
      drive_a(1, -1, 0);
      check_a("a_r_first", -1, 0, 1);
      check("a_r_run", int'(st_a), int'(ST_RUN));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/param_up_sampler.md
PARAM_UP_SAMPLER -- requirements
Module: param_up_sampler

Interface
REQ-001 Parameter WIDTH, default 18, sample word width in bits; legal range 2..32.
REQ-002 Parameter FACTOR, default 4, interpolation ratio L; legal range 2..16.
REQ-003 Parameter MODE, default MODE_ZERO, fill policy; legal values MODE_ZERO (zero-stuff) and MODE_HOLD (zero-order hold).
REQ-004 clk  input  1  output-rate clock.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 sam_en  input  1  one-cycle strobe marking a new input sample on x_in.
REQ-007 x_in  input  WIDTH  signed two's-complement input sample, valid when sam_en=1.
REQ-008 clr_flags  input  1  clears the sticky error flags.
REQ-009 y  output  WIDTH  signed upsampled output, registered.
REQ-010 y_valid  output  1  high on every cycle in which y carries an output-rate sample.
REQ-011 phase  output  clog2(FACTOR)  current output phase; 0 means y is a fresh input sample.
REQ-012 underrun  output  1  sticky flag; set when no strobe arrives by the end of a frame.
REQ-013 overrun  output  1  sticky flag; set when a strobe arrives before the frame is complete.

Function
REQ-014 Two states SHALL exist: IDLE (before the first sam_en) and RUN.
REQ-015 IDLE: y=0, y_valid=0, phase=0. A sam_en in IDLE SHALL capture x_in and move to RUN.
REQ-016 Latency SHALL be 1 cycle: x_in captured on strobe cycle N appears on y in cycle N+1 with phase=0.
REQ-017 In RUN, y_valid=1 on every cycle, and phase SHALL increment by 1 per clk, up to FACTOR-1.
REQ-018 For phase 1..FACTOR-1: MODE_ZERO SHALL output y=0; MODE_HOLD SHALL output y=last captured sample.
REQ-019 Nominal: sam_en asserted on the cycle where phase=FACTOR-1, so the next cycle shows phase=0 with the new sample and no flag is set.
REQ-020 Underrun: phase=FACTOR-1 and no sam_en -> phase wraps to 0, y follows the REQ-018 fill rule for the held sample, and underrun is set.
REQ-021 Overrun: sam_en while phase<FACTOR-1 -> new sample captured, phase restarts at 0 next cycle (resync), overrun set.
REQ-022 Sticky flags SHALL hold until clr_flags=1. If set and clear coincide in the same cycle, set wins.
REQ-023 Samples SHALL pass bit-exact: no gain, scaling, rounding or saturation; y width equals WIDTH.
REQ-024 sam_en held high for multiple cycles SHALL count as a strobe on every cycle; each early one sets overrun.

Reset
REQ-025 reset SHALL take priority over all inputs and force IDLE, y=0, y_valid=0, phase=0, underrun=0, overrun=0, and the held sample to 0.
REQ-026 reset mid-frame SHALL discard the frame. The first sam_en after reset deassertion restarts as REQ-015.

Structure
REQ-027 Package up_sampler_pkg SHALL hold the MODE_ZERO/MODE_HOLD constants, the state enum typedef and the phase-width function.
REQ-028 One sub-module, up_sampler_phase_ctr, SHALL implement the modulo-FACTOR phase counter with sync-restart and wrap-pulse outputs. All other logic stays in param_up_sampler.
REQ-029 Parameter legality SHALL be checked at elaboration; illegal values are a fatal error.

Verification
REQ-030 FACTOR=4, MODE_ZERO, strobes every 4 cycles with x_in=100,-200,300 -> y=100,0,0,0,-200,0,0,0,300,0,0,0; phase cycles 0..3; no flags.
REQ-031 FACTOR=3, MODE_HOLD, x_in=-5 then 7 at nominal timing -> y=-5,-5,-5,7,7,7; y_valid=1 throughout RUN.
REQ-032 FACTOR=4, MODE_ZERO, strobe omitted after sample 50 -> y=50,0,0,0,0,...; phase wraps to 0; underrun=1 until clr_flags.
REQ-033 FACTOR=4, strobe at phase=1 with x_in=9 -> next cycle y=9 and phase=0; overrun=1. clr_flags coinciding with a new overrun event -> overrun stays 1.
REQ-034 Assert reset at phase=2 in RUN -> next cycle y=0, y_valid=0, flags=0, IDLE. Next strobe with x_in=-1 -> y=-1 with phase=0 one cycle later.
REQ-035 WIDTH=18 extremes -131072 and 131071 in both modes -> bit-exact on y with no sign corruption.
